// File: rtl/hci_core_mem_responder_pkg.sv
// Shared types and constants for the HCI-Core memory responder.
// Imported by the responder top and its latency pipe.
package hci_core_mem_responder_pkg;

    localparam int unsigned HCI_BYTE_W    = 8;
    localparam int unsigned HCI_OUT_W_MAX = 16;

    typedef struct packed {
        logic [HCI_OUT_W_MAX-1:0] outstanding;
        logic                     busy;
    } hci_mem_resp_flags_t;

endpackage

// File: rtl/hci_core_mem_responder_if.sv
// HCI-Core single-port bus: request channel plus response channel.
// master/initiator drive requests, slave/target answer them.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) ();

    localparam int unsigned BW = DW / 8;

    logic          req;
    logic          gnt;
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          r_user;
    logic          r_ecc;
    logic          r_opc;

    modport master (
        output req, add, wen, be, data, r_ready,
        input  gnt, r_valid, r_data, r_user, r_ecc, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, r_ready,
        output gnt, r_valid, r_data, r_user, r_ecc, r_opc
    );

    modport initiator (
        output req, add, wen, be, data, r_ready,
        input  gnt, r_valid, r_data, r_user, r_ecc, r_opc
    );

    modport target (
        input  req, add, wen, be, data, r_ready,
        output gnt, r_valid, r_data, r_user, r_ecc, r_opc
    );

endinterface

// File: rtl/hci_core_mem_responder_r_latency_pipe.sv
// Fixed-latency valid/data shift pipeline for read responses.
// Shifts only while enabled; clear and reset drop all valids.
module hci_core_r_latency_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    valid_d;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    // next valid vector: shift in the new read when enabled
    always_comb begin
        valid_d = valid_q;
        if (enable_i) begin
            valid_d[0] = valid_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // valid register, dropped on reset or clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // data payload moves alongside the valids, no reset needed
    always_ff @(posedge clk_i) begin
        if (enable_i) begin
            data_q[0] <= data_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/hci_core_mem_responder.sv
// HCI-Core memory responder: word-addressed bank with fixed read
// latency, credit-limited fall-through response FIFO, stall injection.
module hci_core_mem_responder
    import hci_core_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned RESP_DEPTH   = 4,
    parameter int unsigned STALL_PERIOD = 0,
    localparam int unsigned OUT_W       = $clog2(RESP_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             stall_i,
    hci_core_intf.target     tcdm,
    output logic [OUT_W-1:0] outstanding_o,
    output logic             busy_o
);

    localparam int unsigned BYTES = DATA_WIDTH / HCI_BYTE_W;
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned SC_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SC_W-1:0] SC_LAST =
        SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic            stall_hit;
    logic            credit_ok;
    logic            gnt;
    logic            rd_gnt;
    logic            wr_gnt;
    logic [SC_W-1:0] stall_cnt_q;
    logic [SC_W-1:0] stall_cnt_d;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;

    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    logic [DATA_WIDTH-1:0] fifo_mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [OUT_W-1:0]      fcnt_q, fcnt_d;
    logic                  fifo_empty;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  push;
    logic                  fifo_pop;

    hci_mem_resp_flags_t flags;
    logic                unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx     = tcdm.add[2 +: IDX_W];
    assign rd_word = mem_q[idx];

    // grant: credit check uses registered count, so r_ready never reaches gnt
    always_comb begin
        stall_hit = (STALL_PERIOD > 0) && (stall_cnt_q == SC_LAST);
        credit_ok = (out_q < OUT_W'(RESP_DEPTH));
        gnt       = enable_i & tcdm.req & ~stall_i & ~stall_hit
                  & (~tcdm.wen | credit_ok);
        rd_gnt    = gnt & tcdm.wen;
        wr_gnt    = gnt & ~tcdm.wen;
    end

    // stall counter advances on enabled cycles and wraps at the period
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (enable_i) begin
            if (STALL_PERIOD == 0 || stall_hit) begin
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // memory writes commit at the grant edge, byte by byte
    always_ff @(posedge clk_i) begin
        if (wr_gnt) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (tcdm.be[b]) begin
                    mem_q[idx][b*HCI_BYTE_W +: HCI_BYTE_W] <=
                        tcdm.data[b*HCI_BYTE_W +: HCI_BYTE_W];
                end
            end
        end
    end

    hci_core_r_latency_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LATENCY)
    ) u_pipe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .valid_i  (rd_gnt),
        .data_i   (rd_word),
        .valid_o  (pipe_valid),
        .data_o   (pipe_data)
    );

    // fall-through response FIFO: pipe exit bypasses storage when empty
    always_comb begin
        fifo_empty = (fcnt_q == '0);
        r_valid    = enable_i & (pipe_valid | ~fifo_empty);
        head       = fifo_empty ? pipe_data : fifo_mem_q[rptr_q];
        pop        = r_valid & tcdm.r_ready;
        push       = enable_i & pipe_valid & ~(fifo_empty & pop);
        fifo_pop   = pop & ~fifo_empty;
    end

    // FIFO pointers and credit counter next state
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        fcnt_d = fcnt_q + OUT_W'(push) - OUT_W'(fifo_pop);
        out_d  = out_q + OUT_W'(rd_gnt) - OUT_W'(pop);
        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (fifo_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    // control state register, reset and clear drop everything in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stall_cnt_q <= '0;
            out_q       <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            fcnt_q      <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            out_q       <= out_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // FIFO storage, written only when the pipe exit is not consumed directly
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= pipe_data;
        end
    end

    // status flags derived from the credit counter
    always_comb begin
        flags.outstanding = HCI_OUT_W_MAX'(out_q);
        flags.busy        = (out_q != '0);
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid;
    assign tcdm.r_data  = r_valid ? head : '0;
    assign tcdm.r_user  = 1'b0;
    assign tcdm.r_ecc   = 1'b0;
    assign tcdm.r_opc   = 1'b0;

    assign outstanding_o = flags.outstanding[OUT_W-1:0];
    assign busy_o        = flags.busy;

    assign unused = ^{flags.outstanding, tcdm.add};

endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Self-checking bench for hci_core_mem_responder: three configurations,
// a per-cycle reference model plus directed literal expectations.
module tb_hci_core_mem_responder;

    localparam int N  = 3;
    localparam int MW = 1024;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_s [N];
    logic        wen_s [N];
    logic        rdy_s [N];
    logic        stl_s [N];
    logic        en_s  [N];
    logic        clr_s [N];
    logic [31:0] add_s [N];
    logic [31:0] dat_s [N];
    logic [3:0]  be_s  [N];

    logic        gnt_w  [N];
    logic        rv_w   [N];
    logic [31:0] rd_w   [N];
    logic [2:0]  out_w  [N];
    logic        busy_w [N];
    logic [2:0]  sd_w   [N];

    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hci_core_intf #(.DW(32)) ifc ();
        assign ifc.req     = req_s[g];
        assign ifc.wen     = wen_s[g];
        assign ifc.add     = add_s[g];
        assign ifc.data    = dat_s[g];
        assign ifc.be      = be_s[g];
        assign ifc.r_ready = rdy_s[g];
        assign gnt_w[g]    = ifc.gnt;
        assign rv_w[g]     = ifc.r_valid;
        assign rd_w[g]     = ifc.r_data;
        assign sd_w[g]     = {ifc.r_user, ifc.r_ecc, ifc.r_opc};

        hci_core_mem_responder #(
            .DATA_WIDTH   (32),
            .MEM_WORDS    (MW),
            .LATENCY      ((g == 1) ? 2 : 1),
            .RESP_DEPTH   (D),
            .STALL_PERIOD ((g == 2) ? 3 : 0)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .clear_i       (clr_s[g]),
            .enable_i      (en_s[g]),
            .stall_i       (stl_s[g]),
            .tcdm          (ifc),
            .outstanding_o (out_w[g]),
            .busy_o        (busy_w[g])
        );
    end

    function automatic int lat_of(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int per_of(int i);
        return (i == 2) ? 3 : 0;
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %h, expected %h (t=%0t)",
                     nm, i, act, exp, $time);
        end
    endtask

    // reference model: memory, response queue with enabled-edge ages
    logic [31:0] mmem [N][MW];
    logic [31:0] qd   [N][8];
    int          qc   [N][8];
    int          qn   [N];
    int          scnt [N];
    bit          mvalid = 1'b0;
    logic [31:0] cap_d [N][64];
    int          cap_n [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            qn[i] = 0;
            scnt[i] = 0;
            cap_n[i] = 0;
        end
    end

    // compare process: check every cycle, then advance the model
    always @(negedge clk) begin
        bit          eg;
        bit          erv;
        bit          hit;
        int          idx;
        for (int i = 0; i < N; i++) begin
            idx = int'((add_s[i] >> 2) % MW);
            hit = (per_of(i) > 0) && (scnt[i] == per_of(i) - 1);
            eg  = en_s[i] && req_s[i] && !stl_s[i] && !hit
                  && (!wen_s[i] || qn[i] < D);
            erv = en_s[i] && (qn[i] > 0) && (qc[i][0] >= lat_of(i));
            if (mvalid) begin
                chk("m_gnt", i, 32'(gnt_w[i]), 32'(eg));
                chk("m_rvalid", i, 32'(rv_w[i]), 32'(erv));
                chk("m_outstanding", i, 32'(out_w[i]), 32'(qn[i]));
                chk("m_busy", i, 32'(busy_w[i]), 32'(qn[i] != 0));
                chk("m_rside", i, 32'(sd_w[i]), 32'd0);
                if (erv) chk("m_rdata", i, rd_w[i], qd[i][0]);
            end
            if (rv_w[i] === 1'b1 && rdy_s[i] && en_s[i] && cap_n[i] < 64) begin
                cap_d[i][cap_n[i]] = rd_w[i];
                cap_n[i]++;
            end
            if (eg && !wen_s[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[i][b]) mmem[i][idx][b*8 +: 8] = dat_s[i][b*8 +: 8];
                end
            end
            if (!rst_n || clr_s[i]) begin
                qn[i] = 0;
                scnt[i] = 0;
            end else if (en_s[i]) begin
                if (erv && rdy_s[i]) begin
                    for (int j = 1; j < qn[i]; j++) begin
                        qd[i][j-1] = qd[i][j];
                        qc[i][j-1] = qc[i][j];
                    end
                    qn[i]--;
                end
                for (int j = 0; j < qn[i]; j++) qc[i][j]++;
                if (eg && wen_s[i]) begin
                    qd[i][qn[i]] = mmem[i][idx];
                    qc[i][qn[i]] = 1;
                    qn[i]++;
                end
                if (per_of(i) > 0) scnt[i] = (scnt[i] + 1) % per_of(i);
            end
        end
        if (!rst_n) mvalid = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int i, logic [31:0] a, logic [31:0] d, logic [3:0] b);
        int t;
        t = 0;
        req_s[i] = 1'b1;
        wen_s[i] = 1'b0;
        add_s[i] = a;
        dat_s[i] = d;
        be_s[i]  = b;
        @(negedge clk);
        while (gnt_w[i] !== 1'b1 && t < 50) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk("wr_gnt", i, 32'(gnt_w[i]), 32'd1);
        cyc();
        req_s[i] = 1'b0;
    endtask

    task automatic rd(int i, logic [31:0] a, output logic [31:0] d);
        int t;
        int st;
        st = cap_n[i];
        t = 0;
        rdy_s[i] = 1'b1;
        req_s[i] = 1'b1;
        wen_s[i] = 1'b1;
        add_s[i] = a;
        @(negedge clk);
        while (gnt_w[i] !== 1'b1 && t < 50) begin
            cyc();
            @(negedge clk);
            t++;
        end
        cyc();
        req_s[i] = 1'b0;
        t = 0;
        while (cap_n[i] <= st && t < 50) begin
            cyc();
            t++;
        end
        chk("rd_beat", i, 32'(cap_n[i] > st), 32'd1);
        d = (cap_n[i] > st) ? cap_d[i][st] : 32'hxxxx_xxxx;
    endtask

    logic [31:0] rdat;
    int          issued;
    int          st;
    bit          pat [6];

    initial begin
        for (int i = 0; i < N; i++) begin
            req_s[i] = 0; wen_s[i] = 0; rdy_s[i] = 0; stl_s[i] = 0;
            en_s[i] = 0; clr_s[i] = 0; add_s[i] = 0; dat_s[i] = 0; be_s[i] = 0;
        end
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_gnt", 0, 32'(gnt_w[0]), 32'd0);
        chk("rst_rvalid", 0, 32'(rv_w[0]), 32'd0);
        chk("rst_rdata", 0, rd_w[0], 32'd0);
        chk("rst_out", 0, 32'(out_w[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        cyc();
        rst_n = 1'b1;
        en_s[0] = 1'b1;
        en_s[1] = 1'b1;
        cyc();

        // write then read back with one-cycle latency
        wr(0, 32'h14, 32'hDEADBEEF, 4'hF);
        rdy_s[0] = 1'b1;
        req_s[0] = 1'b1; wen_s[0] = 1'b1; add_s[0] = 32'h14;
        @(negedge clk);
        chk("t1_gnt", 0, 32'(gnt_w[0]), 32'd1);
        chk("t1_rv_at_gnt", 0, 32'(rv_w[0]), 32'd0);
        cyc();
        req_s[0] = 1'b0;
        @(negedge clk);
        chk("t1_rv_lat1", 0, 32'(rv_w[0]), 32'd1);
        chk("t1_rdata", 0, rd_w[0], 32'hDEADBEEF);
        cyc();

        // byte enables
        wr(0, 32'hC, 32'h11223344, 4'hF);
        wr(0, 32'hC, 32'hAABBCCDD, 4'b0101);
        rd(0, 32'hC, rdat);
        chk("be_merge", 0, rdat, 32'h11BB33DD);

        // address wrap and ignored low bits
        wr(0, 32'h0000_101F, 32'hCAFEF00D, 4'hF);
        rd(0, 32'h1C, rdat);
        chk("addr_wrap", 0, rdat, 32'hCAFEF00D);

        // credit limit on the latency-2 instance
        for (int w = 10; w < 16; w++) wr(1, 32'(w * 4), 32'h100 + 32'(w), 4'hF);
        rdy_s[1] = 1'b0;
        issued = 0;
        for (int c = 0; c < 8; c++) begin
            req_s[1] = 1'b1; wen_s[1] = 1'b1; add_s[1] = 32'((10 + issued) * 4);
            @(negedge clk);
            if (gnt_w[1] === 1'b1) issued++;
            cyc();
            add_s[1] = 32'((10 + issued) * 4);
        end
        chk("cr_grants", 1, 32'(issued), 32'd4);
        @(negedge clk);
        chk("cr_gnt_low", 1, 32'(gnt_w[1]), 32'd0);
        chk("cr_out_full", 1, 32'(out_w[1]), 32'd4);
        cyc();
        st = cap_n[1];
        rdy_s[1] = 1'b1;
        @(negedge clk);
        chk("cr_gnt_pop_cycle", 1, 32'(gnt_w[1]), 32'd0);
        chk("cr_first_beat", 1, rd_w[1], 32'h10A);
        cyc();
        @(negedge clk);
        chk("cr_gnt_resume", 1, 32'(gnt_w[1]), 32'd1);
        chk("cr_out_after_pop", 1, 32'(out_w[1]), 32'd3);
        if (gnt_w[1] === 1'b1) issued++;
        cyc();
        for (int c = 0; c < 40 && !(issued == 6 && cap_n[1] - st >= 6); c++) begin
            req_s[1] = (issued < 6);
            add_s[1] = 32'((10 + issued) * 4);
            @(negedge clk);
            if (req_s[1] && gnt_w[1] === 1'b1) issued++;
            cyc();
        end
        req_s[1] = 1'b0;
        chk("cr_beats", 1, 32'(cap_n[1] - st), 32'd6);
        for (int k = 0; k < 6; k++) chk("cr_order", 1, cap_d[1][st + k], 32'h10A + 32'(k));

        // enable low freezes responses and credits
        rdy_s[1] = 1'b0;
        req_s[1] = 1'b1; wen_s[1] = 1'b1; add_s[1] = 32'(10 * 4);
        @(negedge clk);
        cyc();
        req_s[1] = 1'b0;
        repeat (3) cyc();
        en_s[1] = 1'b0; rdy_s[1] = 1'b1; req_s[1] = 1'b1;
        @(negedge clk);
        chk("en0_rvalid", 1, 32'(rv_w[1]), 32'd0);
        chk("en0_gnt", 1, 32'(gnt_w[1]), 32'd0);
        cyc();
        @(negedge clk);
        chk("en0_out_hold", 1, 32'(out_w[1]), 32'd1);
        cyc();
        en_s[1] = 1'b1; req_s[1] = 1'b0;
        @(negedge clk);
        chk("en1_beat", 1, rd_w[1], 32'h10A);
        cyc();

        // mid-operation clear drops in-flight reads
        rdy_s[1] = 1'b0;
        issued = 0;
        for (int c = 0; c < 10 && issued < 3; c++) begin
            req_s[1] = 1'b1; wen_s[1] = 1'b1; add_s[1] = 32'((11 + issued) * 4);
            @(negedge clk);
            if (gnt_w[1] === 1'b1) issued++;
            cyc();
        end
        req_s[1] = 1'b0;
        cyc();
        @(negedge clk);
        chk("clr_out_before", 1, 32'(out_w[1]), 32'd3);
        cyc();
        clr_s[1] = 1'b1;
        cyc();
        clr_s[1] = 1'b0;
        @(negedge clk);
        chk("clr_rvalid", 1, 32'(rv_w[1]), 32'd0);
        chk("clr_out", 1, 32'(out_w[1]), 32'd0);
        st = cap_n[1];
        rdy_s[1] = 1'b1;
        repeat (10) cyc();
        chk("clr_no_late", 1, 32'(cap_n[1] - st), 32'd0);
        rd(1, 32'(11 * 4), rdat);
        chk("clr_mem_kept", 1, rdat, 32'h10B);

        // periodic stall on the STALL_PERIOD=3 instance
        pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0;
        en_s[2] = 1'b1; req_s[2] = 1'b1; wen_s[2] = 1'b0;
        add_s[2] = 32'(100 * 4); be_s[2] = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stall_pat", 2, 32'(gnt_w[2]), 32'(pat[c]));
            cyc();
        end
        stl_s[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stall_ext", 2, 32'(gnt_w[2]), 32'd0);
            cyc();
        end
        stl_s[2] = 1'b0; req_s[2] = 1'b0;

        // streaming reads with random stalls and back-pressure
        for (int w = 0; w < 16; w++) wr(0, 32'(w * 4), 32'hA500_0000 + 32'(w), 4'hF);
        st = cap_n[0];
        issued = 0;
        for (int c = 0; c < 400 && !(issued == 16 && cap_n[0] - st >= 16); c++) begin
            stl_s[0] = ($urandom_range(0, 3) == 0);
            rdy_s[0] = $urandom_range(0, 1) == 1;
            req_s[0] = (issued < 16);
            wen_s[0] = 1'b1;
            add_s[0] = 32'(issued * 4);
            @(negedge clk);
            if (req_s[0] && gnt_w[0] === 1'b1) issued++;
            cyc();
        end
        stl_s[0] = 1'b0; rdy_s[0] = 1'b0; req_s[0] = 1'b0;
        chk("str_beats", 0, 32'(cap_n[0] - st), 32'd16);
        for (int k = 0; k < 16; k++) chk("str_order", 0, cap_d[0][st + k], 32'hA500_0000 + 32'(k));

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
        $fatal(1);
    end

endmodule

// File: doc/hci_core_mem_responder.md
Name: hci_core_mem_responder

Overview:
- HCI-Core target that answers a single initiator port, such as a source or sink streamer, from an internal word-addressed memory array.
- Grants requests subject to credit and stall rules, commits writes at grant, and returns read data after a fixed LATENCY.
- Read responses pass through a credit-limited response FIFO that honours r_ready back-pressure.
- Used as a synthesizable TCDM bank model for streamer benches and small standalone HWPE integrations.

Parameters:
- DATA_WIDTH, 32, tcdm data width in bits; a multiple of 32.
- MEM_WORDS, 1024, number of DATA_WIDTH words in the array; a power of two.
- LATENCY, 1, cycles from grant to earliest r_valid; must be at least 1.
- RESP_DEPTH, 4, maximum outstanding read responses (credits); must be at least LATENCY.
- STALL_PERIOD, 0, deterministic grant suppression; 0 disables it, N>0 forces gnt low one cycle in every N enabled cycles.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- clear_i  in  1  synchronous soft clear.
- enable_i  in  1  global enable.
- stall_i  in  1  external grant suppression for random-stall injection.
- tcdm  hci_core_intf.target  -  req/gnt/add/wen/be/data request channel; r_valid/r_ready/r_data response channel.
- outstanding_o  out  $clog2(RESP_DEPTH+1)  number of granted reads not yet popped.
- busy_o  out  1  high when outstanding_o != 0.

Behaviour:
Reset and clear:
- On rst_ni=0 at a clock edge: pipeline valids, FIFO, credit counter and stall counter all go to 0.
- All outputs low after reset: gnt=0, r_valid=0, r_data=0, outstanding_o=0, busy_o=0.
- Memory contents are not reset and are undefined until written.
- clear_i has the same effect as reset on control state, but preserves memory contents.
- Reset or clear in the middle of operation drops all in-flight responses; nothing is emitted for them.

Request and grant:
- gnt = enable_i & req & ~stall_i & ~stall_hit & (wen==0 | outstanding < RESP_DEPTH).
- gnt is combinational from req within the same cycle.
- Write requests ignore the credit check.

Addressing:
- Word index = add[2 +: $clog2(MEM_WORDS)].
- add[1:0] and all upper bits are ignored; out-of-range addresses wrap modulo MEM_WORDS.

Write (wen=0):
- On a granted edge, byte i of the indexed word is updated with data[8i+:8] for every be[i]=1.
- Writes produce no response beat.

Read (wen=1):
- On a granted edge, the indexed word is sampled into stage 0 of the LATENCY-deep valid/data pipeline.
- A write and a read to the same word cannot share a cycle, because the port takes one request per cycle.
- A read granted in cycle t+1 returns data from the write committed at t.
- At the pipeline exit, the entry is pushed into the response FIFO, which is fall-through.
- r_valid = FIFO not empty; r_data = FIFO head.
- With no back-pressure, r_valid rises exactly LATENCY cycles after the grant cycle.
- FIFO pop occurs on r_valid & r_ready.
- r_data holds stable while r_valid=1 and r_ready=0.
- r_user, r_ecc and r_opc are driven 0.

Credits:
- outstanding increments on each read grant and decrements on each pop.
- A simultaneous grant and pop leaves it unchanged.
- It never exceeds RESP_DEPTH, so the FIFO cannot overflow.
- When it reaches RESP_DEPTH, read gnt stays low until a pop. A pop in the same cycle does not re-enable gnt that cycle; gnt re-enables the next cycle, avoiding a ready-to-gnt combinational path.

Stall counter:
- Counts 0..STALL_PERIOD-1 on enabled cycles, then wraps.
- stall_hit = (STALL_PERIOD>0) & (cnt == STALL_PERIOD-1).

enable_i=0:
- gnt=0 and r_valid=0.
- Pipeline, FIFO, stall counter and credit counter all freeze; no pop occurs regardless of r_ready.

Decomposition:
- hci_package: add hci_mem_resp_flags_t, a struct of outstanding and busy, and a shared localparam HCI_BYTE_W=8.
- One sub-module: hci_core_r_latency_pipe. It is parameterised by DATA_WIDTH and LATENCY, and contains the valid/data shift pipeline with enable and clear.
- The response FIFO reuses the existing hwpe_stream_fifo_passthrough with FIFO_DEPTH=RESP_DEPTH.
- Credit counter, stall counter and memory array stay in the top module.

Test Plan:
- Write, then read back, LATENCY=1: write 0xDEADBEEF to word 5 with be=4'hF, then read word 5 with r_ready=1. Expect r_valid exactly one cycle after the read grant and r_data=0xDEADBEEF.
- Byte enables: preload word 3 with 0x11223344, write 0xAABBCCDD with be=4'b0101, then read word 3. Expect r_data=0x11BB33DD.
- Credit limit, RESP_DEPTH=4, LATENCY=2, r_ready=0: issue 6 back-to-back reads.
  - Expect exactly 4 grants, after which gnt=0 and outstanding_o=4.
  - Raise r_ready: expect 4 pops in order, and grants resume one cycle after the first pop.
- Stall period, STALL_PERIOD=3, req held high: expect the gnt pattern 1,1,0,1,1,0 over 6 cycles; with stall_i=1, expect gnt=0 throughout.
- Mid-operation clear: with 3 reads outstanding, pulse clear_i.
  - Next cycle expect r_valid=0 and outstanding_o=0, and no late beats over 10 cycles.
  - A subsequent read of earlier written data still returns the stored value.
- Drive with hci_core_source in streaming mode: tot_len=16 reads of an incrementing pattern, random stall_i and random r_ready. Expect the stream to deliver words 0..15 in order with no loss or duplication.
